// File: rtl/mem_req_seq.sv
// +----------------------------------------------------------------------------+
// | mem_req_seq : load/store request sequencer for the multi-port memory model  |
// |   Optional read-after-write shadow check enabled by MEM_REQ_SEQ_CHK_EN.     |
// | Revision: 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_req_seq #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16,
   parameter int RD_DLY     = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_addr_wr,
   output logic [DATA_WIDTH-1:0] mem_data_wr,
   output logic                  mem_read,
   output logic [ADDR_WIDTH-1:0] mem_addr_rd,
   input  logic [DATA_WIDTH-1:0] mem_data_rd,
   output logic [15:0]           ld_cnt,
   output logic [15:0]           st_cnt,
   output logic                  chk_err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } state_t;

   // WAIT counts from 0 up to RD_DLY-1; the last count is the sampling cycle.
   localparam logic [1:0] c_dly_last = (RD_DLY > 0) ? 2'(RD_DLY - 1) : 2'd0;

   state_t                  r_state;
   logic [1:0]              r_dly;
   logic                    r_mem_write;
   logic                    r_mem_read;
   logic [ADDR_WIDTH-1:0]   r_addr_wr;
   logic [DATA_WIDTH-1:0]   r_data_wr;
   logic [ADDR_WIDTH-1:0]   r_addr_rd;
   logic                    r_rsp_valid;
   logic [DATA_WIDTH-1:0]   r_rsp_data;
   logic [15:0]             r_ld_cnt;
   logic [15:0]             r_st_cnt;

   logic w_st_acc;
   logic w_ld_acc;
   logic w_sample;

   assign req_ready = (r_state == S_IDLE);
   assign w_st_acc  = req_valid && req_ready && req_we;
   assign w_ld_acc  = req_valid && req_ready && !req_we;
   assign w_sample  = ((r_state == S_RD) && (RD_DLY == 0)) ||
                      ((r_state == S_WAIT) && (r_dly == c_dly_last));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_dly       <= 2'd0;
         r_mem_write <= 1'b0;
         r_mem_read  <= 1'b0;
         r_addr_wr   <= '0;
         r_data_wr   <= '0;
         r_addr_rd   <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_ld_cnt    <= 16'd0;
         r_st_cnt    <= 16'd0;
      end else begin
         r_mem_write <= 1'b0;
         r_mem_read  <= 1'b0;
         if (w_sample) begin
            r_rsp_data <= mem_data_rd;
         end
         case (r_state)
            S_IDLE: begin
               if (w_st_acc) begin
                  r_mem_write <= 1'b1;
                  r_addr_wr   <= req_addr;
                  r_data_wr   <= req_wdata;
                  r_st_cnt    <= r_st_cnt + 16'd1;
               end else if (w_ld_acc) begin
                  r_mem_read <= 1'b1;
                  r_addr_rd  <= req_addr;
                  r_state    <= S_RD;
               end
            end
            S_RD: begin
               r_dly <= 2'd0;
               if (w_sample) begin
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_RESP;
               end else begin
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (w_sample) begin
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_RESP;
               end else begin
                  r_dly <= r_dly + 2'd1;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_ld_cnt    <= r_ld_cnt + 16'd1;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign mem_write   = r_mem_write;
   assign mem_read    = r_mem_read;
   assign mem_addr_wr = r_addr_wr;
   assign mem_data_wr = r_data_wr;
   assign mem_addr_rd = r_addr_rd;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_data    = r_rsp_data;
   assign ld_cnt      = r_ld_cnt;
   assign st_cnt      = r_st_cnt;

`ifdef MEM_REQ_SEQ_CHK_EN
   logic                  r_sh_valid;
   logic [ADDR_WIDTH-1:0] r_sh_addr;
   logic [DATA_WIDTH-1:0] r_sh_data;
   logic                  r_chk_err;

   // Only the most recent store is shadowed; loads elsewhere are not checked.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sh_valid <= 1'b0;
         r_sh_addr  <= '0;
         r_sh_data  <= '0;
         r_chk_err  <= 1'b0;
      end else begin
         if (w_st_acc) begin
            r_sh_valid <= 1'b1;
            r_sh_addr  <= req_addr;
            r_sh_data  <= req_wdata;
         end
         if (w_sample && r_sh_valid && (r_sh_addr == r_addr_rd) &&
             (mem_data_rd != r_sh_data)) begin
            r_chk_err <= 1'b1;
         end
      end
   end

   assign chk_err = r_chk_err;
`else
   assign chk_err = 1'b0;
`endif

endmodule

`default_nettype wire
